// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with redirect flush and stale-response discard
// Optional macro FETCH_BYPASS_EN: present a kept response on out_* in its arrival cycle when the queue is empty.
module fetch_queue #(
  parameter int              PC_W     = 7,
  parameter int              IW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] PC_START = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [PC_W-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [IW-1:0]   mem_resp_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_pc_inc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   head_q, head_d;
  logic [CW-1:0]   tail_q, tail_d;
  logic [IW-1:0]   inst_mem_q [DEPTH];
  logic [IW-1:0]   inst_mem_d [DEPTH];
  logic [PC_W-1:0] pc_mem_q   [DEPTH];
  logic [PC_W-1:0] pc_mem_d   [DEPTH];

  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            empty;
  logic            issue;
  logic            resp_take;
  logic            keep;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] resp_pc;

  always_comb begin
    count     = tail_q - head_q;
    empty     = (count == '0);
    occ       = {1'b0, count} + {1'b0, inflight_q};
    mem_req_valid = reset && !redirect && (occ < DEPTH_C);
    mem_req_addr  = fetch_pc_q;
    issue     = mem_req_valid && mem_req_ready;
    // Responses with nothing in flight belong to requests abandoned by reset.
    resp_take = mem_resp_valid && (inflight_q != '0);
    keep      = resp_take && (discard_q == '0) && !redirect;
    // Kept responses are the oldest of a contiguous run ending just below fetch_pc_q.
    resp_pc   = fetch_pc_q - PC_W'({inflight_q, 2'b00});
`ifdef FETCH_BYPASS_EN
    bypass    = keep && empty;
`else
    bypass    = 1'b0;
`endif
    pop       = !empty && out_ready;
    push      = keep && !(bypass && out_ready);

    if (bypass) begin
      out_valid = 1'b1;
      out_inst  = mem_resp_data;
      out_pc    = resp_pc;
    end else if (!empty) begin
      out_valid = 1'b1;
      out_inst  = inst_mem_q[head_q[AW-1:0]];
      out_pc    = pc_mem_q[head_q[AW-1:0]];
    end else begin
      out_valid = 1'b0;
      out_inst  = '0;
      out_pc    = '0;
    end
    out_pc_inc = out_valid ? (out_pc + PC_W'(4)) : '0;

    inflight_d = inflight_q + CW'(issue) - CW'(resp_take);
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (push) begin
      inst_mem_d[tail_q[AW-1:0]] = mem_resp_data;
      pc_mem_d[tail_q[AW-1:0]]   = resp_pc;
    end

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      discard_d  = inflight_d;
      fetch_pc_d = redirect_pc & ~PC_W'(3);
    end else begin
      head_d     = head_q + CW'(pop);
      tail_d     = tail_q + CW'(push);
      discard_d  = (resp_take && discard_q != '0) ? discard_q - CW'(1) : discard_q;
      fetch_pc_d = issue ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_START;
      inflight_q <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Payload storage needs no reset: out_* are gated by occupancy.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (vector table, directed corners, random vs model)
module tb_fetch_queue;
  localparam int PC_W  = 7;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [PC_W-1:0] PC_START = 7'd0;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [PC_W-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [IW-1:0]   mem_resp_data = '0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IW-1:0]   out_inst;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_pc_inc;

  fetch_queue #(.PC_W(PC_W), .IW(IW), .DEPTH(DEPTH), .PC_START(PC_START)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] inst_of(input logic [PC_W-1:0] a);
    return 32'h1357_9BDF ^ {a, 18'h0, a};
  endfunction

  // Memory model and program-order scoreboard
  logic [PC_W-1:0] mq_addr[$];
  int              mq_due[$];
  int              cyc = 0;
  int              last_due = 0;
  int              lat_min = 1;
  int              lat_max = 1;
  logic            drv_ready = 1'b0;
  logic            drv_oready = 1'b0;
  logic            drv_redirect = 1'b0;
  logic [PC_W-1:0] drv_rpc = '0;
  logic [PC_W-1:0] exp_fetch = '0;
  logic [PC_W-1:0] exp_pc = '0;
  int              consumed = 0;
  int              issued = 0;
  logic            prev_stall = 1'b0;
  logic [PC_W-1:0] prev_addr = '0;

  task automatic tick();
    int due;
    logic [PC_W-1:0] inc;
    @(posedge clk);
    #1;
    cyc++;
    mem_req_ready = drv_ready;
    out_ready     = drv_oready;
    redirect      = drv_redirect;
    redirect_pc   = drv_rpc;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = inst_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    @(negedge clk);
    if (prev_stall && !redirect) begin
      chk("req_hold_valid", mem_req_valid, 1);
      chk("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (redirect) chk("req_during_redirect", mem_req_valid, 0);
    if (out_valid && out_ready) begin
      inc = exp_pc + 7'd4;
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_inst", out_inst, inst_of(exp_pc));
      chk("pop_pc_inc", out_pc_inc, inc);
      exp_pc = inc;
      consumed++;
    end
    if (mem_req_valid && mem_req_ready) begin
      chk("req_addr", mem_req_addr, exp_fetch);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(due);
      exp_fetch = exp_fetch + 7'd4;
      issued++;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    if (redirect) begin
      exp_fetch = drv_rpc & 7'h7C;
      exp_pc    = exp_fetch;
    end
  endtask

  task automatic do_reset(input bit clear_mem);
    @(posedge clk);
    #2;
    reset = 1'b0;
    mem_req_ready = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pc_inc", out_pc_inc, 0);
    @(negedge clk);
    reset = 1'b1;
    if (clear_mem) begin
      mq_addr.delete();
      mq_due.delete();
    end
    last_due = cyc;
    exp_fetch = PC_START;
    exp_pc = PC_START;
    prev_stall = 1'b0;
    drv_redirect = 1'b0;
  endtask

  typedef struct {
    logic rdy; logic rv; logic [PC_W-1:0] raddr; logic rd; logic [PC_W-1:0] rpc; logic ordy;
    logic e_rqv; logic [PC_W-1:0] e_addr;
    logic e_ov;  logic [PC_W-1:0] e_pc;
    logic e_ovb; logic [PC_W-1:0] e_pcb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic ov;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] einc;
    //            rdy   rv    raddr  rd    rpc    ordy  rqv   addr   ov    pc     ovb   pcb
    tbl[0]  = '{1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00};
    tbl[1]  = '{1'b1, 1'b1, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1, 7'h04, 1'b0, 7'h00, 1'b1, 7'h00};
    tbl[2]  = '{1'b1, 1'b1, 7'h04, 1'b0, 7'h00, 1'b1, 1'b1, 7'h08, 1'b1, 7'h00, 1'b1, 7'h04};
    tbl[3]  = '{1'b1, 1'b1, 7'h08, 1'b0, 7'h00, 1'b1, 1'b1, 7'h0C, 1'b1, 7'h04, 1'b1, 7'h08};
    tbl[4]  = '{1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1, 7'h10, 1'b1, 7'h08, 1'b0, 7'h00};
    tbl[5]  = '{1'b1, 1'b0, 7'h00, 1'b1, 7'h2B, 1'b1, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00};
    tbl[6]  = '{1'b1, 1'b1, 7'h0C, 1'b0, 7'h00, 1'b1, 1'b1, 7'h28, 1'b0, 7'h00, 1'b0, 7'h00};
    tbl[7]  = '{1'b1, 1'b1, 7'h10, 1'b0, 7'h00, 1'b1, 1'b1, 7'h2C, 1'b0, 7'h00, 1'b0, 7'h00};
    tbl[8]  = '{1'b1, 1'b1, 7'h28, 1'b0, 7'h00, 1'b1, 1'b1, 7'h30, 1'b0, 7'h00, 1'b1, 7'h28};
    tbl[9]  = '{1'b1, 1'b1, 7'h2C, 1'b0, 7'h00, 1'b1, 1'b1, 7'h34, 1'b1, 7'h28, 1'b1, 7'h2C};
    tbl[10] = '{1'b1, 1'b1, 7'h30, 1'b1, 7'h7C, 1'b1, 1'b0, 7'h00, 1'b1, 7'h2C, 1'b0, 7'h00};
    tbl[11] = '{1'b1, 1'b1, 7'h34, 1'b0, 7'h00, 1'b1, 1'b1, 7'h7C, 1'b0, 7'h00, 1'b0, 7'h00};
    tbl[12] = '{1'b1, 1'b1, 7'h7C, 1'b0, 7'h00, 1'b1, 1'b1, 7'h00, 1'b0, 7'h00, 1'b1, 7'h7C};
    tbl[13] = '{1'b0, 1'b1, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1, 7'h04, 1'b1, 7'h7C, 1'b1, 7'h00};
    tbl[14] = '{1'b0, 1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1, 7'h04, 1'b1, 7'h00, 1'b0, 7'h00};

    do_reset(1'b1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      mem_req_ready  = tbl[i].rdy;
      mem_resp_valid = tbl[i].rv;
      mem_resp_data  = tbl[i].rv ? inst_of(tbl[i].raddr) : '0;
      redirect       = tbl[i].rd;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].ordy;
      @(negedge clk);
`ifdef FETCH_BYPASS_EN
      ov = tbl[i].e_ovb; epc = tbl[i].e_pcb;
`else
      ov = tbl[i].e_ov;  epc = tbl[i].e_pc;
`endif
      einc = epc + 7'd4;
      chk($sformatf("vec%0d_req_valid", i), mem_req_valid, tbl[i].e_rqv);
      if (tbl[i].e_rqv) chk($sformatf("vec%0d_req_addr", i), mem_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_out_valid", i), out_valid, ov);
      if (ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, epc);
        chk($sformatf("vec%0d_out_pc_inc", i), out_pc_inc, einc);
        chk($sformatf("vec%0d_out_inst", i), out_inst, inst_of(epc));
      end
    end

    // Decode stall: occupancy plus in-flight capped at DEPTH, nothing lost on resume
    do_reset(1'b1);
    drv_ready = 1'b1; drv_oready = 1'b0; lat_min = 1; lat_max = 3; issued = 0;
    repeat (10) tick();
    chk("stall_issued", issued, DEPTH);
    chk("stall_req_low", mem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    drv_oready = 1'b1; consumed = 0;
    repeat (20) tick();
    chk("stall_drained", consumed >= DEPTH, 1);

    // Redirect coinciding with a response while the queue is at capacity
    do_reset(1'b1);
    drv_ready = 1'b1; drv_oready = 1'b0; lat_min = 1; lat_max = 1;
    repeat (4) tick();
    drv_redirect = 1'b1; drv_rpc = 7'h45;
    tick();
    chk("cap_redirect_out_valid_before", out_valid, 1);
    drv_redirect = 1'b0;
    tick();
    chk("cap_redirect_out_valid_after", out_valid, 0);
    chk("cap_redirect_req_valid", mem_req_valid, 1);
    chk("cap_redirect_req_addr", mem_req_addr, 7'h44);
    drv_oready = 1'b1; consumed = 0;
    repeat (12) tick();
    chk("cap_redirect_resume", consumed > 0, 1);

    // Reset mid-operation: stale responses after release are ignored
    do_reset(1'b1);
    drv_ready = 1'b1; drv_oready = 1'b1; lat_min = 3; lat_max = 3;
    repeat (3) tick();
    do_reset(1'b0);
    drv_ready = 1'b0;
    tick();
    chk("post_reset_req_valid", mem_req_valid, 1);
    chk("post_reset_req_addr", mem_req_addr, PC_START);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stale_ignored%0d", k), out_valid, 0);
    end
    drv_ready = 1'b1; lat_min = 1; lat_max = 2; consumed = 0;
    repeat (12) tick();
    chk("post_reset_resume", consumed > 0, 1);

    // Randomized traffic against the program-order model
    do_reset(1'b1);
    lat_min = 1; lat_max = 4; consumed = 0;
    repeat (3000) begin
      drv_ready    = ($urandom_range(9, 0) < 7);
      drv_oready   = ($urandom_range(9, 0) < 7);
      drv_redirect = ($urandom_range(19, 0) == 0);
      drv_rpc      = 7'($urandom);
      tick();
    end
    drv_redirect = 1'b0; drv_ready = 1'b1; drv_oready = 1'b1;
    repeat (40) tick();
    chk("random_progress", consumed > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
